// File: rtl/data_io_upload_if.sv
// SPI responder and RAM read-port bundle for data_io_upload.
interface data_io_upload_if;
  logic        sck;
  logic        ss;
  logic        sdi;
  logic        sdo;
  logic        uploading;
  logic [15:0] a;
  logic [7:0]  din;
  logic [15:0] size;
  logic [15:0] count;

  modport master (output sck, ss, sdi, din, size,
                  input  sdo, uploading, a, count);
  modport slave  (input  sck, ss, sdi, din, size,
                  output sdo, uploading, a, count);
endinterface

// File: rtl/data_io_upload.sv
// SPI upload responder: streams a RAM region out on sdo via a 1-byte prefetch buffer.
// Optional: define DATA_IO_UPLOAD_SIZE_EN to compile in the UIO_FILE_RX_SIZE (0x57) command.
module data_io_upload #(
  parameter logic [15:0] START_ADDR = 16'h0000
) (
  input  logic          clk,
  input  logic          reset_n,
  data_io_upload_if.slave bus
);

  localparam logic [7:0] UIO_FILE_RX      = 8'h55;
  localparam logic [7:0] UIO_FILE_RX_DAT  = 8'h56;
`ifdef DATA_IO_UPLOAD_SIZE_EN
  localparam logic [7:0] UIO_FILE_RX_SIZE = 8'h57;
`endif

  typedef enum logic [1:0] {PF_IDLE, PF_ISSUE, PF_CAPTURE} pf_state_t;

  logic [2:0]  sck_sr;
  logic [1:0]  ss_sr;
  logic [1:0]  sdi_sr;
  logic        sck_rise;
  logic        sck_fall;
  logic        ss_q;
  logic        sdi_q;

  logic [3:0]  cnt;
  logic [6:0]  rx_sr;
  logic [7:0]  cmd;
  logic [7:0]  shreg;
  logic        sdo_q;
  logic        uploading_q;
  logic [15:0] byte_addr;
  logic [15:0] count_q;
  logic [7:0]  pbuf;
  logic [7:0]  load_byte;
  logic        start_req;
  logic        consume_req;
  logic        prefetch_req;
  pf_state_t   pf_state;
  pf_state_t   pf_next;
`ifdef DATA_IO_UPLOAD_SIZE_EN
  logic [1:0]  slot;
  logic [7:0]  size_hi;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_sr <= '0;
      ss_sr  <= '1;
      sdi_sr <= '0;
    end else begin
      sck_sr <= {sck_sr[1:0], bus.sck};
      ss_sr  <= {ss_sr[0], bus.ss};
      sdi_sr <= {sdi_sr[0], bus.sdi};
    end
  end

  assign ss_q     = ss_sr[1];
  assign sdi_q    = sdi_sr[1];
  assign sck_rise = sck_sr[1] & ~sck_sr[2] & ~ss_q;
  assign sck_fall = ~sck_sr[1] & sck_sr[2] & ~ss_q;

  assign start_req    = sck_rise && (cnt == 4'd15) && (cmd == UIO_FILE_RX) && sdi_q;
  assign consume_req  = sck_rise && (cnt == 4'd15) && (cmd == UIO_FILE_RX_DAT) && uploading_q;
  assign prefetch_req = start_req || consume_req;

  always_comb begin
    load_byte = '0;
    if (cmd == UIO_FILE_RX_DAT) begin
      if (uploading_q) load_byte = (count_q >= bus.size) ? 8'hFF : pbuf;
    end
`ifdef DATA_IO_UPLOAD_SIZE_EN
    else if (cmd == UIO_FILE_RX_SIZE) begin
      case (slot)
        2'd0:    load_byte = bus.size[7:0];
        2'd1:    load_byte = size_hi;
        default: load_byte = '0;
      endcase
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      rx_sr       <= '0;
      cmd         <= '0;
      shreg       <= '0;
      sdo_q       <= 1'b0;
      uploading_q <= 1'b0;
      byte_addr   <= START_ADDR;
      count_q     <= '0;
`ifdef DATA_IO_UPLOAD_SIZE_EN
      slot        <= '0;
      size_hi     <= '0;
`endif
    end else if (ss_q) begin
      // Deselect drops any partial byte; session state is kept across frames.
      cnt   <= '0;
      cmd   <= '0;
      shreg <= '0;
      sdo_q <= 1'b0;
`ifdef DATA_IO_UPLOAD_SIZE_EN
      slot  <= '0;
`endif
    end else begin
      if (sck_rise) begin
        cnt   <= (cnt == 4'd15) ? 4'd8 : cnt + 4'd1;
        rx_sr <= {rx_sr[5:0], sdi_q};
        if (cnt == 4'd7) cmd <= {rx_sr, sdi_q};
        if (cnt == 4'd15 && cmd == UIO_FILE_RX) begin
          uploading_q <= sdi_q;
          if (sdi_q) begin
            byte_addr <= START_ADDR;
            count_q   <= '0;
          end
        end else if (consume_req) begin
          byte_addr <= byte_addr + 16'd1;
          if (count_q != 16'hFFFF) count_q <= count_q + 16'd1;
        end
      end
      if (sck_fall) begin
        if (cnt == 4'd8) begin
          shreg <= load_byte;
          sdo_q <= load_byte[7];
`ifdef DATA_IO_UPLOAD_SIZE_EN
          if (cmd == UIO_FILE_RX_SIZE && slot == 2'd0) size_hi <= bus.size[15:8];
          if (slot != 2'd2) slot <= slot + 2'd1;
`endif
        end else if (cnt > 4'd8) begin
          shreg <= {shreg[6:0], 1'b0};
          sdo_q <= shreg[6];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pf_state <= PF_IDLE;
    else          pf_state <= pf_next;
  end

  // The RAM samples a at the end of ISSUE, so din is valid during CAPTURE.
  always_comb begin
    pf_next = pf_state;
    case (pf_state)
      PF_IDLE:    pf_next = PF_IDLE;
      PF_ISSUE:   pf_next = PF_CAPTURE;
      PF_CAPTURE: pf_next = PF_IDLE;
      default:    pf_next = PF_IDLE;
    endcase
    if (prefetch_req) pf_next = PF_ISSUE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    pbuf <= '0;
    else if (pf_state == PF_CAPTURE) pbuf <= bus.din;
  end

  assign bus.a         = byte_addr;
  assign bus.sdo       = sdo_q;
  assign bus.uploading = uploading_q;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_data_io_upload.sv
// Bench for data_io_upload: two instances (START_ADDR 0000 and FFFE) against a byte-level model.
module tb_data_io_upload;
  localparam int H = 6;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sck = 1'b0;
  logic ss = 1'b1;
  logic sdi = 1'b0;
  logic [15:0] size = '0;
  logic [7:0] mem [0:65535];

  always #5 clk = ~clk;

  data_io_upload_if if0();
  data_io_upload_if if1();

  assign if0.sck = sck;  assign if0.ss = ss;  assign if0.sdi = sdi;  assign if0.size = size;
  assign if1.sck = sck;  assign if1.ss = ss;  assign if1.sdi = sdi;  assign if1.size = size;

  always @(posedge clk) begin
    if0.din <= mem[if0.a];
    if1.din <= mem[if1.a];
  end

  data_io_upload u_dut0 (.clk(clk), .reset_n(reset_n), .bus(if0));
  data_io_upload #(.START_ADDR(16'hFFFE)) u_dut1 (.clk(clk), .reset_n(reset_n), .bus(if1));

  int n_chk = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  logic [15:0] sa [2] = '{16'h0000, 16'hFFFE};
  logic [15:0] m_addr [2];
  logic [15:0] m_count [2];
  logic        m_up [2];
  logic [7:0]  rx0 [8];
  logic [7:0]  rx1 [8];

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_addr[k] = sa[k];
      m_count[k] = '0;
      m_up[k] = 1'b0;
    end
  endtask

  // Byte a completed slot must have carried, then advance the session state.
  function automatic logic [7:0] model_slot(input int k, input logic [7:0] cmd, input int idx,
                                            input logic [7:0] tx);
    logic [7:0] r;
    r = 8'h00;
    if (cmd == 8'h55) begin
      m_up[k] = tx[0];
      if (tx[0]) begin
        m_addr[k] = sa[k];
        m_count[k] = '0;
      end
    end else if (cmd == 8'h56 && m_up[k]) begin
      r = (m_count[k] >= size) ? 8'hFF : mem[m_addr[k]];
      m_addr[k] = m_addr[k] + 16'd1;
      if (m_count[k] != 16'hFFFF) m_count[k] = m_count[k] + 16'd1;
    end
`ifdef DATA_IO_UPLOAD_SIZE_EN
    else if (cmd == 8'h57) begin
      r = (idx == 0) ? size[7:0] : (idx == 1) ? size[15:8] : 8'h00;
    end
`endif
    return r;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("idle_sdo0", {15'd0, if0.sdo}, 16'd0);
      check("idle_sdo1", {15'd0, if1.sdo}, 16'd0);
      check("idle_up0", {15'd0, if0.uploading}, {15'd0, m_up[0]});
      check("idle_up1", {15'd0, if1.uploading}, {15'd0, m_up[1]});
      check("idle_count0", if0.count, m_count[0]);
      check("idle_count1", if1.count, m_count[1]);
      check("idle_a0", if0.a, m_addr[0]);
      check("idle_a1", if1.a, m_addr[1]);
    end
  end

  task automatic spi_bit(input logic b, output logic s0, output logic s1);
    sdi = b;
    repeat (H) @(negedge clk);
    s0 = if0.sdo;
    s1 = if1.sdo;
    sck = 1'b1;
    repeat (H) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic frame(input logic [7:0] cmd, input int nslots, input logic [7:0] tx,
                       input int cut_bits, input bit cut_reset);
    logic s0, s1;
    logic [7:0] r0, r1, e0, e1;
    chk_en = 1'b0;
    ss = 1'b0;
    repeat (H) @(negedge clk);
    for (int i = 7; i >= 0; i--) spi_bit(cmd[i], s0, s1);
    for (int s = 0; s < nslots; s++) begin
      r0 = '0;
      r1 = '0;
      for (int i = 7; i >= 0; i--) begin
        spi_bit(tx[i], s0, s1);
        r0 = {r0[6:0], s0};
        r1 = {r1[6:0], s1};
      end
      e0 = model_slot(0, cmd, s, tx);
      e1 = model_slot(1, cmd, s, tx);
      check("slot_byte0", {8'd0, r0}, {8'd0, e0});
      check("slot_byte1", {8'd0, r1}, {8'd0, e1});
      rx0[s] = r0;
      rx1[s] = r1;
    end
    for (int i = 7; i > 7 - cut_bits; i--) spi_bit(tx[i], s0, s1);
    if (cut_reset) begin
      reset_n = 1'b0;
      #1;
      check("rst_sdo0", {15'd0, if0.sdo}, 16'd0);
      check("rst_up0", {15'd0, if0.uploading}, 16'd0);
      check("rst_count0", if0.count, 16'd0);
      check("rst_a1", if1.a, 16'hFFFE);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
    end
    repeat (H) @(negedge clk);
    ss = 1'b1;
    repeat (H + 2) @(negedge clk);
    chk_en = 1'b1;
  endtask

  initial begin
    logic [7:0] c;
    int ns, cut;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    mem[16'hFFFE] = 8'hAA; mem[16'hFFFF] = 8'hBB;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_sdo", {15'd0, if0.sdo}, 16'd0);
    check("reset_up", {15'd0, if0.uploading}, 16'd0);
    check("reset_count", if0.count, 16'd0);
    check("reset_a0", if0.a, 16'h0000);
    check("reset_a1", if1.a, 16'hFFFE);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk_en = 1'b1;

    size = 16'd4;
    frame(8'h55, 1, 8'h01, 0, 1'b0);
    check("t1_up_on", {15'd0, if0.uploading}, 16'd1);
    frame(8'h56, 4, 8'h00, 0, 1'b0);
    check("t1_b0", {8'd0, rx0[0]}, 16'h11);
    check("t1_b1", {8'd0, rx0[1]}, 16'h22);
    check("t1_b2", {8'd0, rx0[2]}, 16'h33);
    check("t1_b3", {8'd0, rx0[3]}, 16'h44);
    check("t1_count", if0.count, 16'd4);
    frame(8'h55, 1, 8'h00, 0, 1'b0);
    check("t1_up_off", {15'd0, if0.uploading}, 16'd0);

    size = 16'd2;
    frame(8'h55, 1, 8'h01, 0, 1'b0);
    frame(8'h56, 4, 8'h00, 0, 1'b0);
    check("t2_b1", {8'd0, rx0[1]}, 16'h22);
    check("t2_b2", {8'd0, rx0[2]}, 16'hFF);
    check("t2_b3", {8'd0, rx0[3]}, 16'hFF);
    check("t2_count", if0.count, 16'd4);
    check("t2_a", if0.a, 16'd4);

    mem[0] = 8'hCC;
    size = 16'd3;
    frame(8'h55, 1, 8'h01, 0, 1'b0);
    frame(8'h56, 3, 8'h00, 0, 1'b0);
    check("t3_b0", {8'd0, rx1[0]}, 16'hAA);
    check("t3_b1", {8'd0, rx1[1]}, 16'hBB);
    check("t3_b2", {8'd0, rx1[2]}, 16'hCC);
    check("t3_a", if1.a, 16'h0001);
    frame(8'h55, 1, 8'h00, 0, 1'b0);
    repeat (4) @(negedge clk);
    mem[0] = 8'h11;

    size = 16'd4;
    frame(8'h55, 1, 8'h01, 0, 1'b0);
    frame(8'h56, 1, 8'h00, 4, 1'b0);
    check("t4_count", if0.count, 16'd1);
    frame(8'h56, 1, 8'h00, 0, 1'b0);
    check("t4_resend", {8'd0, rx0[0]}, 16'h22);

    frame(8'h56, 0, 8'h00, 4, 1'b1);
    frame(8'h56, 1, 8'h00, 0, 1'b0);
    check("t5_after_rst", {8'd0, rx0[0]}, 16'h00);

    size = 16'h1234;
    frame(8'h57, 3, 8'h00, 0, 1'b0);
`ifdef DATA_IO_UPLOAD_SIZE_EN
    check("t6_s0", {8'd0, rx0[0]}, 16'h34);
    check("t6_s1", {8'd0, rx0[1]}, 16'h12);
`else
    check("t6_s0", {8'd0, rx0[0]}, 16'h00);
    check("t6_s1", {8'd0, rx0[1]}, 16'h00);
`endif
    check("t6_s2", {8'd0, rx0[2]}, 16'h00);

    for (int it = 0; it < 70; it++) begin
      size = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 10));
      cut = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 7) : 0;
      case ($urandom_range(0, 3))
        0: begin
          c = {7'($urandom), ($urandom_range(0, 3) != 0)};
          frame(8'h55, 1, c, 0, 1'b0);
        end
        1: begin
          ns = $urandom_range(1, 5);
          frame(8'h56, ns, 8'($urandom), cut, ($urandom_range(0, 9) == 0) && cut != 0);
        end
        2: frame(8'h57, $urandom_range(1, 3), 8'($urandom), cut, 1'b0);
        default: begin
          c = 8'h10 + 8'($urandom_range(0, 63));
          frame(c, $urandom_range(1, 2), 8'($urandom), cut, 1'b0);
        end
      endcase
    end

    chk_en = 1'b0;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/data_io_upload.md
# data_io_upload

SPI responder for uploads from FPGA memory to the IO controller: the FPGA streams a RAM region back to the controller, e.g. to save a tape or memory image. The block sits beside the download path on the same SPI select line and uses the same command/byte framing. It decodes the upload commands, reads a synchronous RAM through its own read port, and shifts bytes out MSB-first on `sdo`. Everything runs in the `clk` domain; `sck`, `ss` and `sdi` are oversampled.

## Interface
- `START_ADDR`, 16'h0000: first RAM address sent after an upload start.
- `clk` in 1: system clock; every register in the block uses this clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `sck` in 1: SPI clock from the IO controller, asynchronous to `clk`.
- `ss` in 1: SPI select, active-high deselect.
- `sdi` in 1: SPI data from the IO controller.
- `sdo` out 1: SPI data to the IO controller; 0 when not in an upload data slot.
- `uploading` out 1: upload session active.
- `a` out 16: RAM read address; RAM has 1-clk read latency.
- `din` in 8: RAM read data, valid 1 clk after `a`.
- `size` in 16: number of valid bytes in the upload region.
- `count` out 16: bytes fully sent in the current session.

## Operation
- Sync: `sck`, `ss`, `sdi` each pass through 2 flops. The block detects rise and fall of `sck` on the synchronized copy.
- Bit counter `cnt[3:0]`:
  - Synchronized `ss` high: `cnt` is 0.
  - Each `sck` rise: `cnt` counts 0..15, then 15 -> 8.
  - Bits 0-7 form the command byte, MSB first. Bits 8-15 repeat as data slots.
- Command register: latched at the rise where `cnt`==7. Cleared to 0 by `ss` high.
- Commands:
  - UIO_FILE_RX 8'h55: flag byte; bit 0 is the last bit, sampled at `cnt`==15.
    - Flag 1: `byte_addr`<=START_ADDR, `count`<=0, `uploading`<=1, prefetch issued.
    - Flag 0: `uploading`<=0; `byte_addr` and `count` hold.
  - UIO_FILE_RX_DAT 8'h56: each slot returns one RAM byte; valid only while `uploading`=1. With `uploading`=0 the slot returns 8'h00.
  - Other commands: `sdo`=0 and no state change.
- Prefetch buffer `pbuf[7:0]` always holds RAM[`byte_addr`] once the FSM is in IDLE.
- Prefetch FSM:
  - IDLE -> ISSUE: on a prefetch request. The request comes from an upload start or from a byte consume.
  - ISSUE: drive `a`=`byte_addr`, then go to CAPTURE.
  - CAPTURE: `pbuf`<=`din`, then go to IDLE.
  - `a` holds `byte_addr` at all times.
- Load: at the `sck` fall with `cnt`==8 in an 0x56 slot, `shreg`<=`pbuf` and `sdo`<=`pbuf[7]`.
- Shift: at each following fall in the slot, `sdo` takes the next lower bit.
- Consume: at the rise with `cnt`==15 in an 0x56 slot:
  - `byte_addr`<=`byte_addr`+1, wrapping FFFF->0000.
  - `count`<=`count`+1, saturating at FFFF.
  - Prefetch issued.
- Past end: when `count` >= `size`, the slot loads 8'hFF instead of `pbuf`. Address and count still advance.

## Timing
- `sck` high and low phases must each last at least 4 `clk` periods. Prefetch (2 clk) then completes before the next fall.
- `sdo` changes 3 clk after the physical `sck` fall (2 sync + 1 register). The controller samples on `sck` rise (SPI mode 0).
- `uploading` changes 3 clk after the physical rise of flag bit 0.
- Reset (`reset_n`=0), any time, asynchronously sets:
  - `sdo`=0, `uploading`=0, `count`=0, `a`=START_ADDR.
  - `cnt`=0, command register 0, FSM IDLE, `pbuf`=0.
- `ss` rising mid-slot: partial byte discarded, no consume, `sdo`<=0. `uploading`, `byte_addr` and `count` persist across `ss` cycles.
- New start while `uploading`=1: restarts from START_ADDR.
- If a consume and a start occur together, the start wins. This cannot happen within one frame.

## Configuration
- `DATA_IO_UPLOAD_SIZE_EN` defined: command UIO_FILE_RX_SIZE 8'h57 is compiled in.
  - Slot 1 returns `size[7:0]`, slot 2 returns `size[15:8]`, later slots return 8'h00.
  - `size` is sampled at the slot 1 load.
  - No effect on `byte_addr` or `count`.
- Undefined: 8'h57 is treated as an unknown command and `sdo` stays 0.

## Test plan
- RAM[0..3]=11,22,33,44, `size`=4. Send 55/01, then 56 with 4 slots, then 55/00.
  - Required: MISO bytes 11,22,33,44; `count`=4; `uploading` 1 then 0.
- `size`=2, same RAM, 4 slots of 56.
  - Required: 11,22,FF,FF; `count`=4; `a` ends at 4.
- `START_ADDR`=FFFE, RAM[FFFE]=AA, RAM[FFFF]=BB, RAM[0]=CC, `size`=3.
  - Required: AA,BB,CC; `a` wraps to 0000 and then reads 0001.
- Raise `ss` after 4 bits of the second slot, then start a new 56 frame.
  - Required: the new frame's first byte is 22, i.e. the aborted byte is resent; `count`=1 before the new frame.
- Pulse `reset_n` low mid-slot.
  - Required: `sdo`=0, `uploading`=0, `count`=0 immediately. A following 56 frame returns 00.
- `DATA_IO_UPLOAD_SIZE_EN` defined, `size`=1234, send 57 with 3 slots.
  - Required: 34,12,00. Without the macro: 00,00,00.
